tc_multi: RTL and testbench

- Multi-channel timer/counter device for the MIPS SoC bus. Successor to the single-channel TC, with N_CH independent down-counters, per-channel one-shot/auto-reload mode, power-of-two prescaler, byte-enabled writes, per-channel maskable interrupts and an OR-reduced interrupt line.
- Sits behind the Bridge as one device slot. The Bridge performs base decode and passes word address, write data, byte enables and write enable. irq_any feeds one CPU HWInt bit.

---
 rtl/tc_multi_pkg.sv | 26 ++
 rtl/tc_multi_channel.sv | 92 +++++++++
 rtl/tc_multi.sv | 82 ++++++++
 tb/tb_tc_multi.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/tc_multi_pkg.sv
// Shared constants for the multi-channel timer/counter: register offsets,
// CTRL field positions, channel FSM encoding and mode values.
package tc_multi_pkg;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_PRESET = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_MODE   = 1;
  localparam int CTRL_IM     = 2;
  localparam int CTRL_PS_LSB = 3;
  localparam int CTRL_PS_MSB = 6;
  localparam int CTRL_W      = 7;

  localparam logic MODE_ONESHOT = 1'b0;
  localparam logic MODE_RELOAD  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2
  } ch_state_e;

endpackage

// File: rtl/tc_multi_channel.sv
// One timer channel: CTRL/PRESET/COUNT/pend registers, power-of-two
// prescaler and the IDLE/LOAD/CNT sequencer.
module tc_channel
  import tc_multi_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic              clk,
  input  logic              sys_rstn,
  input  logic [3:0]        ctrl_we,
  input  logic [3:0]        preset_we,
  input  logic              pend_clr,
  input  logic [31:0]       wdata,
  output logic [CTRL_W-1:0] ctrl,
  output logic [CNT_W-1:0]  preset,
  output logic [CNT_W-1:0]  count,
  output logic              pend
);

  ch_state_e         state_r;
  logic [15:0]       presc_r;
  logic [CTRL_W-1:0] ctrl_wr_s;
  logic [CNT_W-1:0]  preset_wr_s;
  logic [15:0]       ps_mask_s;
  logic              tick_s;

  // Byte-masked next values of the writable registers.
  always_comb begin
    ctrl_wr_s = ctrl_we[0] ? wdata[CTRL_W-1:0] : ctrl;
    for (int b = 0; b < CNT_W; b++) begin
      preset_wr_s[b] = preset_we[b/8] ? wdata[b] : preset[b];
    end
    ps_mask_s = (16'd1 << ctrl[CTRL_PS_MSB:CTRL_PS_LSB]) - 16'd1;
    tick_s    = (presc_r == ps_mask_s);
  end

  // Register file, prescaler and channel sequencer.
  always_ff @(posedge clk) begin
    if (!sys_rstn) begin
      ctrl    <= '0;
      preset  <= '0;
      count   <= '0;
      pend    <= 1'b0;
      presc_r <= 16'd0;
      state_r <= ST_IDLE;
    end else begin
      ctrl   <= ctrl_wr_s;
      preset <= preset_wr_s;
      if (pend_clr) begin
        pend <= 1'b0;
      end
      case (state_r)
        ST_IDLE: begin
          if (ctrl_wr_s[CTRL_EN]) begin
            state_r <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          count   <= preset;
          presc_r <= 16'd0;
          state_r <= ST_CNT;
        end
        ST_CNT: begin
          if (!ctrl[CTRL_EN]) begin
            state_r <= ST_IDLE;
          end else if (tick_s) begin
            presc_r <= 16'd0;
            if (count <= CNT_W'(1)) begin
              count <= '0;
              pend  <= 1'b1;
              if (ctrl[CTRL_MODE] == MODE_RELOAD) begin
                state_r <= ST_LOAD;
              end else begin
                // A CTRL write landing on expiry keeps its own EN value.
                if (!ctrl_we[0]) begin
                  ctrl <= {ctrl_wr_s[CTRL_W-1:1], 1'b0};
                end
                state_r <= ST_IDLE;
              end
            end else begin
              count <= count - CNT_W'(1);
            end
          end else begin
            presc_r <= presc_r + 16'd1;
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/tc_multi.sv
// Multi-channel timer/counter bus slave: address decode, channel array,
// read-back mux and interrupt reduction.
module tc_multi
  import tc_multi_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int CNT_W = 32
) (
  input  logic            clk,
  input  logic            sys_rstn,
  input  logic [29:0]     Addr,
  input  logic            WE,
  input  logic [3:0]      byteen,
  input  logic [31:0]     Din,
  output logic [31:0]     Dout,
  output logic [N_CH-1:0] IRQ,
  output logic            irq_any
);

  // One extra index bit so channel N_CH decodes as out of range instead of aliasing.
  localparam int CH_W = $clog2(N_CH + 1);

  logic [CH_W-1:0]   ch_idx_s;
  logic [1:0]        reg_s;
  logic              unused_addr;
  logic [CTRL_W-1:0] ch_ctrl_s   [N_CH];
  logic [CNT_W-1:0]  ch_preset_s [N_CH];
  logic [CNT_W-1:0]  ch_count_s  [N_CH];
  logic              ch_pend_s   [N_CH];
  logic [31:0]       rd_word_s   [N_CH];

  assign ch_idx_s    = Addr[CH_W+1:2];
  assign reg_s       = Addr[1:0];
  assign unused_addr = &{1'b0, Addr[29:CH_W+2]};

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic hit_s;
    assign hit_s = WE && (ch_idx_s == CH_W'(i));

    tc_channel #(.CNT_W(CNT_W)) u_ch (
      .clk       (clk),
      .sys_rstn  (sys_rstn),
      .ctrl_we   ((hit_s && reg_s == REG_CTRL)   ? byteen : 4'b0000),
      .preset_we ((hit_s && reg_s == REG_PRESET) ? byteen : 4'b0000),
      .pend_clr  (hit_s && reg_s == REG_STATUS && byteen[0] && Din[0]),
      .wdata     (Din),
      .ctrl      (ch_ctrl_s[i]),
      .preset    (ch_preset_s[i]),
      .count     (ch_count_s[i]),
      .pend      (ch_pend_s[i])
    );

    assign IRQ[i] = ch_pend_s[i] & ch_ctrl_s[i][CTRL_IM];

    // Per-channel read word, zero unless this channel is addressed.
    always_comb begin
      rd_word_s[i] = 32'd0;
      if (ch_idx_s == CH_W'(i)) begin
        case (reg_s)
          REG_CTRL:   rd_word_s[i] = 32'(ch_ctrl_s[i]);
          REG_PRESET: rd_word_s[i] = 32'(ch_preset_s[i]);
          REG_COUNT:  rd_word_s[i] = 32'(ch_count_s[i]);
          REG_STATUS: rd_word_s[i] = {31'd0, ch_pend_s[i]};
          default:    rd_word_s[i] = 32'd0;
        endcase
      end else begin
        rd_word_s[i] = 32'd0;
      end
    end
  end

  // OR of the one-hot-selected channel read words.
  always_comb begin
    Dout = 32'd0;
    for (int i = 0; i < N_CH; i++) begin
      Dout = Dout | rd_word_s[i];
    end
  end

  assign irq_any = |IRQ;

endmodule

// File: tb/tb_tc_multi.sv
// Directed self-checking bench for tc_multi (N_CH=4, CNT_W=32).
module tb_tc_multi;

  logic        clk;
  logic        sys_rstn;
  logic [29:0] Addr;
  logic        WE;
  logic [3:0]  byteen;
  logic [31:0] Din;
  logic [31:0] Dout;
  logic [3:0]  IRQ;
  logic        irq_any;

  int errors = 0;
  int checks = 0;
  logic [31:0] rdata;

  tc_multi #(.N_CH(4), .CNT_W(32)) dut (
    .clk(clk), .sys_rstn(sys_rstn), .Addr(Addr), .WE(WE),
    .byteen(byteen), .Din(Din), .Dout(Dout), .IRQ(IRQ), .irq_any(irq_any)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [29:0] ra(input int ch, input int r);
    return 30'(ch * 4 + r);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic wr(input logic [29:0] a, input logic [3:0] be, input logic [31:0] d);
    @(negedge clk);
    Addr = a; byteen = be; Din = d; WE = 1'b1;
    @(negedge clk);
    WE = 1'b0; byteen = 4'b0000;
  endtask

  task automatic rd(input logic [29:0] a, output logic [31:0] d);
    Addr = a;
    #1;
    d = Dout;
  endtask

  initial begin
    sys_rstn = 1'b0; Addr = 30'd0; WE = 1'b0; byteen = 4'b0000; Din = 32'd0;
    // Reset overrides a same-cycle write
    @(negedge clk);
    Addr = ra(0, 1); byteen = 4'b1111; Din = 32'h0000_00FF; WE = 1'b1;
    repeat (2) @(negedge clk);
    WE = 1'b0; sys_rstn = 1'b1;

    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        rd(ra(c, r), rdata);
        chk($sformatf("reset_reg_c%0d_r%0d", c, r), rdata, 32'h0000_0000);
      end
    end
    chk("reset_irq", {28'd0, IRQ}, 32'd0);
    chk("reset_irq_any", {31'd0, irq_any}, 32'd0);

    // ch0 one-shot, PRESET=5, PS=0
    wr(ra(0, 1), 4'b1111, 32'd5);
    wr(ra(0, 0), 4'b1111, 32'h5);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      rd(ra(0, 2), rdata);
      chk($sformatf("ch0_count_E%0d", k), rdata, 32'(6 - k));
    end
    chk("ch0_irq_before", {28'd0, IRQ}, 32'd0);
    @(negedge clk);
    chk("ch0_irq_expire", {28'd0, IRQ}, 32'h1);
    rd(ra(0, 0), rdata);
    chk("ch0_ctrl_en_cleared", rdata, 32'h4);
    rd(ra(0, 2), rdata);
    chk("ch0_count_zero", rdata, 32'd0);
    wr(ra(0, 3), 4'b0001, 32'd1);
    chk("ch0_w1c", {28'd0, IRQ}, 32'd0);

    // ch2 auto-reload, PRESET=3: expiries at E4, E8
    wr(ra(2, 1), 4'b1111, 32'd3);
    wr(ra(2, 0), 4'b1111, 32'h7);
    repeat (3) @(negedge clk);
    chk("ch2_irq_E3", {28'd0, IRQ}, 32'd0);
    @(negedge clk);
    chk("ch2_irq_E4", {28'd0, IRQ}, 32'h4);
    Addr = ra(2, 3); byteen = 4'b0001; Din = 32'd1; WE = 1'b1;
    @(negedge clk);
    WE = 1'b0;
    chk("ch2_w1c_E5", {28'd0, IRQ}, 32'd0);
    repeat (2) @(negedge clk);
    chk("ch2_irq_E7", {28'd0, IRQ}, 32'd0);
    Addr = ra(2, 3); byteen = 4'b0001; Din = 32'd1; WE = 1'b1;
    @(negedge clk);
    WE = 1'b0;
    chk("ch2_set_beats_w1c_E8", {28'd0, IRQ}, 32'h4);
    rd(ra(2, 3), rdata);
    chk("ch2_status_E8", rdata, 32'd1);
    wr(ra(2, 0), 4'b1111, 32'h0);
    wr(ra(2, 3), 4'b0001, 32'd1);
    repeat (6) @(negedge clk);
    chk("ch2_stopped_irq_any", {31'd0, irq_any}, 32'd0);

    // ch1 one-shot, PRESET=2, PS=2, IM=0: expiry at E9
    wr(ra(1, 1), 4'b1111, 32'd2);
    wr(ra(1, 0), 4'b1111, 32'h11);
    @(negedge clk);
    rd(ra(1, 2), rdata);
    chk("ch1_count_E1", rdata, 32'd2);
    repeat (3) @(negedge clk);
    rd(ra(1, 2), rdata);
    chk("ch1_count_E4", rdata, 32'd2);
    @(negedge clk);
    rd(ra(1, 2), rdata);
    chk("ch1_count_E5", rdata, 32'd1);
    repeat (3) @(negedge clk);
    rd(ra(1, 3), rdata);
    chk("ch1_status_E8", rdata, 32'd0);
    @(negedge clk);
    rd(ra(1, 3), rdata);
    chk("ch1_status_E9", rdata, 32'd1);
    chk("ch1_irq_masked", {28'd0, IRQ}, 32'd0);
    chk("ch1_irq_any_masked", {31'd0, irq_any}, 32'd0);
    wr(ra(1, 0), 4'b1111, 32'h14);
    chk("ch1_irq_unmasked", {28'd0, IRQ}, 32'h2);
    chk("ch1_irq_any_unmasked", {31'd0, irq_any}, 32'd1);
    wr(ra(1, 3), 4'b0001, 32'd1);
    chk("ch1_irq_any_cleared", {31'd0, irq_any}, 32'd0);

    // Byte enables, out-of-range channel, read-only COUNT
    wr(ra(3, 1), 4'b1111, 32'h1122_3344);
    wr(ra(3, 1), 4'b0011, 32'hAABB_CCDD);
    rd(ra(3, 1), rdata);
    chk("byteen_0011", rdata, 32'h1122_CCDD);
    wr(ra(3, 1), 4'b0000, 32'hFFFF_FFFF);
    rd(ra(3, 1), rdata);
    chk("byteen_0000", rdata, 32'h1122_CCDD);
    wr(ra(3, 1), 4'b1000, 32'h5500_0000);
    rd(ra(3, 1), rdata);
    chk("byteen_1000", rdata, 32'h5522_CCDD);
    wr(ra(4, 1), 4'b1111, 32'hDEAD_BEEF);
    wr(ra(4, 0), 4'b1111, 32'h1);
    rd(ra(4, 1), rdata);
    chk("oor_read", rdata, 32'd0);
    rd(ra(0, 1), rdata);
    chk("oor_no_alias_preset", rdata, 32'd5);
    rd(ra(0, 0), rdata);
    chk("oor_no_alias_ctrl", rdata, 32'h4);
    wr(ra(3, 2), 4'b1111, 32'h0000_1234);
    rd(ra(3, 2), rdata);
    chk("count_ro", rdata, 32'd0);

    // Reset mid-count on ch0
    wr(ra(0, 0), 4'b1111, 32'h5);
    repeat (3) @(negedge clk);
    rd(ra(0, 2), rdata);
    chk("ch0_pre_reset_count", rdata, 32'd3);
    sys_rstn = 1'b0;
    @(negedge clk);
    sys_rstn = 1'b1;
    for (int r = 0; r < 4; r++) begin
      rd(ra(0, r), rdata);
      chk($sformatf("midreset_ch0_r%0d", r), rdata, 32'd0);
    end
    rd(ra(3, 1), rdata);
    chk("midreset_ch3_preset", rdata, 32'd0);
    repeat (10) @(negedge clk);
    chk("midreset_no_irq", {28'd0, IRQ}, 32'd0);
    rd(ra(0, 3), rdata);
    chk("midreset_no_pend", rdata, 32'd0);

    // EN=0 mid-count freezes COUNT
    wr(ra(0, 1), 4'b1111, 32'd10);
    wr(ra(0, 0), 4'b1111, 32'h5);
    repeat (3) @(negedge clk);
    rd(ra(0, 2), rdata);
    chk("freeze_count_E3", rdata, 32'd8);
    wr(ra(0, 0), 4'b1111, 32'h4);
    rd(ra(0, 2), rdata);
    chk("freeze_count_E5", rdata, 32'd6);
    repeat (15) @(negedge clk);
    rd(ra(0, 2), rdata);
    chk("freeze_count_held", rdata, 32'd6);
    chk("freeze_no_irq", {28'd0, IRQ}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
